// File: rtl/vgachargen_map_arbiter.sv
// Map RAM arbiter: display fetch has absolute priority with fixed latency,
// bus side gets a 1-entry posted write buffer and single-outstanding reads.
module vgachargen_map_arbiter #(
  parameter int H_WIDTH    = 7,
  parameter int V_WIDTH    = 5,
  parameter int ADDR_WIDTH = H_WIDTH + V_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int H_CELLS    = 80,
  parameter int V_CELLS    = 30
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  disp_req_i,
  input  logic [ADDR_WIDTH-1:0] disp_addr_i,
  output logic                  disp_rvalid_o,
  output logic [DATA_WIDTH-1:0] disp_rdata_o,
  input  logic                  bus_req_i,
  input  logic                  bus_we_i,
  input  logic [ADDR_WIDTH-1:0] bus_addr_i,
  input  logic [DATA_WIDTH-1:0] bus_wdata_i,
  output logic                  bus_gnt_o,
  output logic                  bus_rvalid_o,
  output logic [DATA_WIDTH-1:0] bus_rdata_o,
  output logic                  bus_err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [H_WIDTH:0] H_LIM = (H_WIDTH+1)'(H_CELLS);
  localparam logic [V_WIDTH:0] V_LIM = (V_WIDTH+1)'(V_CELLS);

  logic                  wbuf_valid;
  logic [ADDR_WIDTH-1:0] wbuf_addr;
  logic [DATA_WIDTH-1:0] wbuf_data;
  logic                  disp_d1;
  logic                  disp_d2;
  logic                  rd_p1;
  logic                  rd_p2;
  logic                  rd_e1;
  logic                  rd_e2;
  logic                  rd_pending;

  logic [H_WIDTH-1:0]    col;
  logic [V_WIDTH-1:0]    row;
  logic                  oor;
  logic                  acc;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  drain;

  logic                  nxt_en;
  logic                  nxt_we;
  logic [ADDR_WIDTH-1:0] nxt_addr;

  assign col = bus_addr_i[H_WIDTH-1:0];
  assign row = bus_addr_i[ADDR_WIDTH-1:H_WIDTH];
  assign oor = ({1'b0, col} >= H_LIM) || ({1'b0, row} >= V_LIM);

  assign rd_pending = rd_p1 | rd_p2;

  // Reads also wait for the buffer so they always observe posted writes.
  assign bus_gnt_o = bus_we_i
                   ? (!wbuf_valid || !disp_req_i)
                   : (!disp_req_i && !wbuf_valid && !rd_pending);

  assign acc    = bus_req_i && bus_gnt_o;
  assign wr_acc = acc && bus_we_i && !oor;
  assign rd_acc = acc && !bus_we_i && !oor;
  assign drain  = wbuf_valid && !disp_req_i;

  always_comb begin
    nxt_en   = 1'b0;
    nxt_we   = 1'b0;
    nxt_addr = mem_addr_o;
    unique case (1'b1)
      disp_req_i: begin
        nxt_en   = 1'b1;
        nxt_addr = disp_addr_i;
      end
      drain: begin
        nxt_en   = 1'b1;
        nxt_we   = 1'b1;
        nxt_addr = wbuf_addr;
      end
      rd_acc: begin
        nxt_en   = 1'b1;
        nxt_addr = bus_addr_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_en_o      <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      wbuf_valid    <= 1'b0;
      wbuf_addr     <= '0;
      wbuf_data     <= '0;
      disp_d1       <= 1'b0;
      disp_d2       <= 1'b0;
      disp_rvalid_o <= 1'b0;
      disp_rdata_o  <= '0;
      rd_p1         <= 1'b0;
      rd_p2         <= 1'b0;
      rd_e1         <= 1'b0;
      rd_e2         <= 1'b0;
      bus_rvalid_o  <= 1'b0;
      bus_rdata_o   <= '0;
      bus_err_o     <= 1'b0;
    end else begin
      mem_en_o   <= nxt_en;
      mem_we_o   <= nxt_we;
      mem_addr_o <= nxt_addr;
      if (nxt_we) begin
        mem_wdata_o <= wbuf_data;
      end

      if (wr_acc) begin
        wbuf_valid <= 1'b1;
        wbuf_addr  <= bus_addr_i;
        wbuf_data  <= bus_wdata_i;
      end else if (drain) begin
        wbuf_valid <= 1'b0;
      end

      disp_d1       <= disp_req_i;
      disp_d2       <= disp_d1;
      disp_rvalid_o <= disp_d2;
      if (disp_d2) begin
        disp_rdata_o <= mem_rdata_i;
      end

      // Out-of-range reads keep the same timing but return zero.
      rd_p1        <= acc && !bus_we_i;
      rd_e1        <= acc && !bus_we_i && oor;
      rd_p2        <= rd_p1;
      rd_e2        <= rd_e1;
      bus_rvalid_o <= rd_p2;
      if (rd_p2) begin
        bus_rdata_o <= rd_e2 ? '0 : mem_rdata_i;
      end

      bus_err_o <= acc && oor;
    end
  end

endmodule
